// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array loader.
// Provides the loader FSM state encoding, default row/address widths and a
// helper that extracts one column element from a packed row.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } loader_state_t;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned SIZE      = 3;
  localparam int unsigned N_ROWS    = 6;
  localparam int unsigned ROW_W     = DATA_SIZE * SIZE;
  localparam int unsigned MAX_DEPTH = (SIZE > N_ROWS) ? SIZE : N_ROWS;
  localparam int unsigned ADDR_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  // Column c of a packed row; column 0 sits in the MSBs.
  function automatic logic [DATA_SIZE-1:0] col_slice(input logic [ROW_W-1:0] row,
                                                     input int unsigned       c);
    return row[(SIZE - c) * DATA_SIZE - 1 -: DATA_SIZE];
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Row register file: depth x row_w storage, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk      : write clock
//   wr_en    : write strobe (address already range-checked by the caller)
//   wr_addr  : write row index
//   wr_data  : write row
//   rd_addr  : read row index
//   rd_data  : read row (zero for out-of-range index)
module row_buffer
  import systolic_pkg::*;
#(
  parameter int unsigned depth = 3,
  parameter int unsigned row_w = 24,
  localparam int unsigned AW   = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [row_w-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [row_w-1:0] rd_data
);

  logic [row_w-1:0] mem [depth];

  // Storage write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Unused encodings of a non-power-of-two depth read as zero
  assign rd_data = (32'(rd_addr) < depth) ? mem[rd_addr] : '0;

endmodule

// File: rtl/systolic_loader.sv
// Upstream sequencer for the systolic array. Buffers one weight matrix and
// one block of input rows, then on start drives set_w/w_stream for size
// cycles, data_stream for n_rows cycles, flush_cycles zero rows and a done
// pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data : host row write (sel 0 weights, 1 data)
//   wr_ready    : writes accepted (IDLE only)
//   start       : run request, sampled in IDLE
//   busy, done  : run in progress / end-of-run pulse
//   set_w, w_stream, data_stream : array feed, all registered
module systolic_loader
  import systolic_pkg::*;
#(
  parameter int unsigned data_size    = 8,
  parameter int unsigned size         = 3,
  parameter int unsigned n_rows       = 6,
  parameter int unsigned flush_cycles = 4,
  localparam int unsigned RW    = data_size * size,
  localparam int unsigned MAX_D = (size > n_rows) ? size : n_rows,
  localparam int unsigned AW    = (MAX_D > 1) ? $clog2(MAX_D) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [RW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          set_w,
  output logic [RW-1:0] w_stream,
  output logic [RW-1:0] data_stream
);

  localparam int unsigned MAX_SD = (size > n_rows) ? size : n_rows;
  localparam int unsigned MAX_C  = (MAX_SD > flush_cycles) ? MAX_SD : flush_cycles;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);
  localparam int unsigned WAW    = (size > 1) ? $clog2(size) : 1;
  localparam int unsigned DAW    = (n_rows > 1) ? $clog2(n_rows) : 1;
  localparam int unsigned LAST_W = size - 1;
  localparam int unsigned LAST_D = n_rows - 1;
  localparam int unsigned LAST_F = (flush_cycles > 0) ? flush_cycles - 1 : 0;

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wr_acc, w_we, d_we;
  logic [WAW-1:0]   w_wa, w_ra;
  logic [DAW-1:0]   d_wa, d_ra;
  logic [RW-1:0]    w_rd, d_rd, w_row, d_row;

  logic             set_w_d, busy_d, done_d;
  logic [RW-1:0]    w_stream_d, data_stream_d;

  assign wr_ready = (state_q == IDLE);

  // Host write decode; out-of-range rows are dropped
  assign wr_acc = wr_en && wr_ready;
  assign w_we   = wr_acc && !wr_sel && (32'(wr_addr) < size);
  assign d_we   = wr_acc &&  wr_sel && (32'(wr_addr) < n_rows);
  assign w_wa   = WAW'(wr_addr);
  assign d_wa   = DAW'(wr_addr);

  row_buffer #(.depth(size), .row_w(RW)) u_w_buf (
    .clk     (clk),
    .wr_en   (w_we),
    .wr_addr (w_wa),
    .wr_data (wr_data),
    .rd_addr (w_ra),
    .rd_data (w_rd)
  );

  row_buffer #(.depth(n_rows), .row_w(RW)) u_d_buf (
    .clk     (clk),
    .wr_en   (d_we),
    .wr_addr (d_wa),
    .wr_data (wr_data),
    .rd_addr (d_ra),
    .rd_data (d_rd)
  );

  // State and phase counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each phase counts its own rows from zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (cnt_q == CNT_W'(LAST_W)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STREAM: begin
        if (cnt_q == CNT_W'(LAST_D)) begin
          state_d = (flush_cycles == 0) ? DONE : FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(LAST_F)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up
  // with the state they describe. A write landing on the row being fetched
  // is forwarded, so a same-cycle write+start sees the new row.
  always_comb begin
    w_ra          = WAW'(cnt_d);
    d_ra          = DAW'(cnt_d);
    w_row         = (w_we && (w_wa == w_ra)) ? wr_data : w_rd;
    d_row         = (d_we && (d_wa == d_ra)) ? wr_data : d_rd;
    set_w_d       = (state_d == LOAD_W);
    busy_d        = (state_d == LOAD_W) || (state_d == STREAM) || (state_d == FLUSH);
    done_d        = (state_d == DONE);
    w_stream_d    = set_w_d ? w_row : '0;
    data_stream_d = (state_d == STREAM) ? d_row : '0;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_w       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_stream    <= '0;
      data_stream <= '0;
    end else begin
      set_w       <= set_w_d;
      busy        <= busy_d;
      done        <= done_d;
      w_stream    <= w_stream_d;
      data_stream <= data_stream_d;
    end
  end

endmodule

// File: tb/tb_systolic_loader.sv
// Self-checking bench for systolic_loader: default configuration plus an
// edge configuration (size=4, n_rows=1, flush_cycles=0).
module tb_systolic_loader;
  import systolic_pkg::*;

  localparam int SZ = 3, NR = 6, FL = 4, RW = 24, AW = 3;
  localparam int SZB = 4, NRB = 1, RWB = 32, AWB = 2;
  localparam int TOT = SZ + NR + FL + 1;
  localparam int TOTB = SZB + NRB + 0 + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wr_en, wr_sel, wr_ready, start, busy, done, set_w;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data, w_stream, data_stream;

  logic           b_wr_en, b_wr_sel, b_wr_ready, b_start, b_busy, b_done, b_set_w;
  logic [AWB-1:0] b_wr_addr;
  logic [RWB-1:0] b_wr_data, b_w_stream, b_data_stream;

  systolic_loader #(.data_size(8), .size(SZ), .n_rows(NR), .flush_cycles(FL)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .busy(busy), .done(done),
    .set_w(set_w), .w_stream(w_stream), .data_stream(data_stream));

  systolic_loader #(.data_size(8), .size(SZB), .n_rows(NRB), .flush_cycles(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_ready(b_wr_ready), .start(b_start), .busy(b_busy),
    .done(b_done), .set_w(b_set_w), .w_stream(b_w_stream), .data_stream(b_data_stream));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference contents of the two buffers of the default instance
  logic [RW-1:0]  wm [SZ];
  logic [RW-1:0]  dm [NR];
  logic [RWB-1:0] wb [SZB];
  logic [RWB-1:0] db;

  typedef struct {
    int         cyc;
    logic       r, s, b, d;
    logic [23:0] w, ds;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pk_a(input logic r, s, b, d, input logic [RW-1:0] w, ds);
    return {76'b0, r, s, b, d, w, ds};
  endfunction

  function automatic logic [127:0] pk_b(input logic r, s, b, d, input logic [RWB-1:0] w, ds);
    return {60'b0, r, s, b, d, w, ds};
  endfunction

  function automatic logic [127:0] snap_a();
    return pk_a(wr_ready, set_w, busy, done, w_stream, data_stream);
  endfunction

  function automatic logic [127:0] snap_b();
    return pk_b(b_wr_ready, b_set_w, b_busy, b_done, b_w_stream, b_data_stream);
  endfunction

  // Expected outputs k cycles after the start-sampling edge
  function automatic logic [127:0] exp_a(input int k);
    if (k <= SZ)           return pk_a(1'b0, 1'b1, 1'b1, 1'b0, wm[k-1], '0);
    if (k <= SZ + NR)      return pk_a(1'b0, 1'b0, 1'b1, 1'b0, '0, dm[k-SZ-1]);
    if (k <= SZ + NR + FL) return pk_a(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    if (k == TOT)          return pk_a(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    return pk_a(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endfunction

  function automatic logic [127:0] exp_b(input int k);
    if (k <= SZB)       return pk_b(1'b0, 1'b1, 1'b1, 1'b0, wb[k-1], '0);
    if (k <= SZB + NRB) return pk_b(1'b0, 1'b0, 1'b1, 1'b0, '0, db);
    if (k == TOTB)      return pk_b(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    return pk_b(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endfunction

  task automatic wr_a(input logic sel, input int addr, input logic [RW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel && addr < NR) dm[addr] = data;
    if (!sel && addr < SZ) wm[addr] = data;
  endtask

  // Start a run and check every cycle through the first idle cycle.
  // At cycle inj (if >0) a start and a weight-row-0 write are attempted.
  task automatic run_a(input string nm, input int inj);
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= TOT + 1; k++) begin
      check($sformatf("%s_c%0d", nm, k), snap_a(), exp_a(k));
      if (k == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = '1;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    int   nset;

    tbl[0]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 24'h010203, 24'h000000};
    tbl[1]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 24'h040506, 24'h000000};
    tbl[2]  = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 24'h070809, 24'h000000};
    tbl[3]  = '{4,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h010101};
    tbl[4]  = '{5,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h020202};
    tbl[5]  = '{6,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h030303};
    tbl[6]  = '{7,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h040404};
    tbl[7]  = '{8,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h050505};
    tbl[8]  = '{9,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h060606};
    tbl[9]  = '{10, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[10] = '{11, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[11] = '{12, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[12] = '{13, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tbl[13] = '{14, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000};
    tbl[14] = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};

    rst_n = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    b_wr_en = 1'b0; b_wr_sel = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_a", snap_a(), pk_a(1'b1, 1'b0, 1'b0, 1'b0, '0, '0));
    check("reset_b", snap_b(), pk_b(1'b1, 1'b0, 1'b0, 1'b0, '0, '0));

    // Basic run against the hand-written table
    wr_a(1'b0, 0, 24'h010203);
    wr_a(1'b0, 1, 24'h040506);
    wr_a(1'b0, 2, 24'h070809);
    for (int r = 0; r < NR; r++) wr_a(1'b1, r, {3{8'(r + 1)}});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("basic_c%0d", tbl[i].cyc), snap_a(),
            pk_a(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].d, tbl[i].w, tbl[i].ds));
      if (i == 0) begin
        check("col0_msb", 128'(col_slice(w_stream, 0)), 128'(8'h01));
        check("col2_lsb", 128'(col_slice(w_stream, 2)), 128'(8'h03));
      end
      tick();
    end

    // Start and write during STREAM are ignored; next run keeps row 0
    run_a("busy_prot", 6);
    run_a("after_prot", 0);

    // Same-cycle write and start
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 24'h0A0B0C;
    wm[0] = 24'h0A0B0C;
    run_a("wr_start", 0);

    // Random loads including out-of-range addresses
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 12; j++)
        wr_a(1'($urandom), int'($urandom_range(0, 7)), RW'($urandom));
      run_a($sformatf("rand%0d", r), 0);
    end

    // Reset during LOAD_W row 1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_row1", snap_a(), exp_a(2));
    #2 rst_n = 1'b0;
    #1 check("async_rst", snap_a(), pk_a(1'b1, 1'b0, 1'b0, 1'b0, '0, '0));
    tick(); tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen_done |= done;
    end
    check("no_done_after_abort", 128'(seen_done), 128'(1'b0));
    run_a("replay", 0);

    // Edge configuration: size=4 counter must not wrap, no flush
    for (int i = 0; i < SZB; i++) begin
      wb[i] = RWB'(32'h11223344 * (i + 1));
      b_wr_en = 1'b1; b_wr_sel = 1'b0; b_wr_addr = AWB'(i); b_wr_data = wb[i];
      tick();
    end
    db = 32'hAABBCCDD;
    b_wr_en = 1'b1; b_wr_sel = 1'b1; b_wr_addr = '0; b_wr_data = db;
    tick();
    b_wr_en = 1'b1; b_wr_sel = 1'b1; b_wr_addr = AWB'(1); b_wr_data = 32'hDEADBEEF;
    tick();
    b_wr_en = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    nset = 0;
    for (int k = 1; k <= TOTB + 1; k++) begin
      check($sformatf("edge_c%0d", k), snap_b(), exp_b(k));
      nset += int'(b_set_w);
      tick();
    end
    check("edge_setw_count", 128'(nset), 128'(SZB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
